// File: rtl/prog_byte_loader_pkg.sv
// Shared constants and state encoding for the program byte loader.
// Optional feature: PLOADER_CHECKSUM_EN adds the CHK state.
package prog_byte_loader_pkg;
  localparam int ADDR_LEN         = 16;
  localparam int LOADER_MAX_BYTES = 8192;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
`ifdef PLOADER_CHECKSUM_EN
    S_CHK   = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Destination once the payload, and any padding of its last line, is written.
`ifdef PLOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CHK;
`else
  localparam state_t S_POST = S_DONE;
`endif

  function automatic logic [127:0] line_shift(input logic [127:0] line, input logic [31:0] w);
    return {w, line[127:32]};
  endfunction
endpackage

// File: rtl/prog_word_asm.sv
// Little-endian byte-to-word assembler; shared by header, payload and checksum.
module prog_word_asm (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);
  logic [1:0]  cnt;
  logic [23:0] lo;

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      cnt <= '0;
      lo  <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    lo[7:0]   <= din;
        2'd1:    lo[15:8]  <= din;
        2'd2:    lo[23:16] <= din;
        default: lo        <= '0;
      endcase
    end
  end

  // The completed word is valid only in the cycle the 4th byte is accepted.
  assign word = {din, lo};
  assign last = en && (cnt == 2'd3);
endmodule

// File: rtl/prog_byte_loader.sv
// Streams a length-prefixed program into dmem words and imem lines.
// Define PLOADER_CHECKSUM_EN to require a trailing 32-bit payload checksum.
module prog_byte_loader
  import prog_byte_loader_pkg::*;
#(
  parameter int MAX_BYTES = LOADER_MAX_BYTES
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADDR_LEN-1:0] addr,
  output logic [127:0]        data,
  output logic                we_32,
  output logic                we_128,
  output logic                done,
  output logic                err
);
  state_t              state, state_nxt;
  logic                run_q, rdy, acc, last;
  logic [31:0]         word, len_raw;
  logic [ADDR_LEN-1:0] waddr, len;
`ifdef PLOADER_CHECKSUM_EN
  logic [31:0]         sum;
`endif

  assign acc      = in_valid & in_ready;
  assign in_ready = run_q & rdy;
  assign len_raw  = word & ~32'd3;

  prog_word_asm u_asm (
    .clk     (clk),
    .reset_x (reset_x),
    .en      (acc),
    .din     (in_data),
    .word    (word),
    .last    (last)
  );

  // Exits from LOAD/FLUSH are taken in the strobe cycle, so done follows the final write.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      S_HDR: begin
        rdy = 1'b1;
        if (last) begin
          if (len_raw == 32'd0)                 state_nxt = S_DONE;
          else if (len_raw > 32'(MAX_BYTES))    state_nxt = S_ERR;
          else                                  state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        rdy = (waddr != len);
        if (we_32 && waddr == len)
          state_nxt = (addr[3:2] == 2'd3) ? S_POST : S_FLUSH;
      end
      S_FLUSH: if (we_128) state_nxt = S_POST;
`ifdef PLOADER_CHECKSUM_EN
      S_CHK: begin
        rdy = 1'b1;
        if (last) state_nxt = (word == sum) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state  <= S_HDR;
      run_q  <= 1'b0;
      addr   <= '0;
      waddr  <= '0;
      len    <= '0;
      data   <= '0;
      we_32  <= 1'b0;
      we_128 <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef PLOADER_CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      run_q  <= 1'b1;
      we_32  <= 1'b0;
      we_128 <= 1'b0;
      done   <= done | (state_nxt == S_DONE);
      err    <= err  | (state_nxt == S_ERR);
      if (state == S_HDR && last) len <= len_raw[ADDR_LEN-1:0];
      if (state == S_LOAD && last) begin
        data   <= line_shift(data, word);
        addr   <= waddr;
        waddr  <= waddr + ADDR_LEN'(4);
        we_32  <= 1'b1;
        we_128 <= (waddr[3:2] == 2'd3);
`ifdef PLOADER_CHECKSUM_EN
        sum    <= sum + word;
`endif
      end
      // Zero-pad a partial line; stop shifting once its line strobe is out.
      if (state == S_FLUSH && !we_128) begin
        data   <= line_shift(data, 32'd0);
        addr   <= waddr;
        waddr  <= waddr + ADDR_LEN'(4);
        we_128 <= (waddr[3:2] == 2'd3);
      end
    end
  end
endmodule

// File: tb/tb_prog_byte_loader.sv
// Directed and randomized bench for prog_byte_loader against a line-level reference model.
module tb_prog_byte_loader;
  import prog_byte_loader_pkg::*;
  localparam int MAXB = LOADER_MAX_BYTES;

  logic                clk = 1'b0, reset_x = 1'b0, in_valid = 1'b0;
  logic [7:0]          in_data = '0;
  logic                in_ready, we_32, we_128, done, err;
  logic [ADDR_LEN-1:0] addr;
  logic [127:0]        data;

  typedef struct packed {
    logic [ADDR_LEN-1:0] a;
    logic                w32;
    logic                w128;
    logic [127:0]        d;
  } ev_t;

  ev_t obs_q[$], exp_q[$];
  int  obs_cyc[$];
  int  cyc = 0, done_cyc = -1;
  int  n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  prog_byte_loader dut (
    .clk(clk), .reset_x(reset_x), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr(addr), .data(data), .we_32(we_32),
    .we_128(we_128), .done(done), .err(err)
  );

  always @(negedge clk) begin
    cyc++;
    if (we_32 || we_128) begin
      obs_q.push_back('{addr, we_32, we_128, data});
      obs_cyc.push_back(cyc);
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    reset_x = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    obs_q.delete(); obs_cyc.delete(); done_cyc = -1;
    @(posedge clk); #1;
    chk("rst_out", {addr, data, we_32, we_128, done, err, in_ready}, '0);
    chk("rst_nostrobe", obs_q.size(), 0);
    reset_x = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 3)) begin
      in_valid = 1'b0; @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $error("FAIL send_tmo: in_ready stuck low, want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Reference: payload words, zero-padded to whole lines, move through a 4-word window.
  task automatic build_exp(input logic [7:0] pl[$]);
    int nw = pl.size() / 4;
    int ns = ((nw + 3) / 4) * 4;
    logic [31:0] s[$];
    exp_q.delete();
    for (int k = 0; k < ns; k++)
      s.push_back(k < nw ? {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]} : 32'd0);
    for (int k = 0; k < ns; k++) begin
      logic [127:0] d = '0;
      for (int j = 0; j < 4; j++)
        if (k - j >= 0) d[32*(3-j) +: 32] = s[k-j];
      if (k < nw)          exp_q.push_back('{ADDR_LEN'(4*k), 1'b1, (k % 4) == 3, d});
      else if (k % 4 == 3) exp_q.push_back('{ADDR_LEN'(4*k), 1'b0, 1'b1, d});
    end
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, ":nev"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s:addr%0d", tag, i), obs_q[i].a, exp_q[i].a);
      chk($sformatf("%s:we%0d", tag, i), {obs_q[i].w32, obs_q[i].w128}, {exp_q[i].w32, exp_q[i].w128});
      chk($sformatf("%s:data%0d", tag, i), obs_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] len, input bit seq,
                          input bit rnd, input bit bad);
    logic [31:0] lm, sum;
    logic [7:0]  pl[$];
    bit          exp_err;
    int          n = 0;
    do_reset();
    exp_q.delete();
    lm = len & ~32'd3;
    for (int i = 0; i < 4; i++) send(len[8*i +: 8], rnd);
    if (lm == 0) begin
      chk({tag, ":len0_done"}, done, 1'b1);
    end else if (lm > MAXB) begin
      chk({tag, ":big_err"}, err, 1'b1);
      chk({tag, ":big_rdy"}, in_ready, 1'b0);
    end else begin
      sum = '0;
      for (int i = 0; i < lm; i++) pl.push_back(seq ? 8'(i) : 8'($urandom));
      for (int i = 0; i < lm; i++) send(pl[i], rnd);
      build_exp(pl);
      for (int k = 0; k < lm / 4; k++) sum += {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
`ifdef PLOADER_CHECKSUM_EN
      if (bad) sum += 32'd1;
      for (int i = 0; i < 4; i++) send(sum[8*i +: 8], rnd);
`endif
    end
    while (!(done || err) && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk); #1;
    exp_err = (lm > MAXB);
`ifdef PLOADER_CHECKSUM_EN
    exp_err = exp_err || (bad && lm != 0);
`endif
    chk({tag, ":done"}, done, !exp_err);
    chk({tag, ":err"}, err, exp_err);
    chk({tag, ":rdy_end"}, in_ready, 1'b0);
    cmp_events(tag);
`ifndef PLOADER_CHECKSUM_EN
    if (lm == 16 && obs_cyc.size() > 0)
      chk({tag, ":done_next"}, done_cyc, obs_cyc[obs_cyc.size()-1] + 1);
`endif
  endtask

  initial begin
    do_reset();
    run_load("full",  32'd16, 1'b1, 1'b0, 1'b0);
    run_load("part",  32'd8,  1'b1, 1'b0, 1'b0);
    run_load("len0",  32'd0,  1'b1, 1'b0, 1'b0);
    run_load("big",   32'h2010, 1'b1, 1'b0, 1'b0);
    run_load("bp",    32'd16, 1'b1, 1'b1, 1'b0);
    // Abandon a load part-way through its second word.
    do_reset();
    for (int i = 0; i < 4; i++) send(i == 0 ? 8'd16 : 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 1'b0);
    run_load("midrst", 32'd4,  1'b0, 1'b0, 1'b0);
    run_load("lowbits", 32'd13, 1'b0, 1'b1, 1'b0);
    run_load("len3",  32'd3,  1'b0, 1'b0, 1'b0);
`ifdef PLOADER_CHECKSUM_EN
    run_load("badsum", 32'd16, 1'b1, 1'b0, 1'b1);
`endif
    for (int r = 0; r < 6; r++)
      run_load($sformatf("rnd%0d", r), 32'(4 * $urandom_range(1, 40)), 1'b0, 1'b1, 1'b0);
    run_load("max",   32'(MAXB),     1'b0, 1'b0, 1'b0);
    run_load("max4",  32'(MAXB + 4), 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
